csr_dbg_arbiter: RTL and testbench
==================================

Name: csr_dbg_arbiter

Overview:
Shares the single M-stage CSR access port (address, write strobe, write value, read value) between the pipeline and the debug module's abstract-command interface. Pipeline accesses always win. Debug accesses are issued in idle slots. On RV32, 64-bit debug accesses to paired low/high CSRs (e.g. STIMECMP/STIMECMPH) are sequenced as hazard-free multi-beat transactions, so no spurious timer interrupt and no torn read occurs. Sits between the M-stage CSR decode and the CSR register blocks.

Parameters:
XLEN, 64, datapath width (32 or 64)
STARVE_LIMIT, 8, consecutive blocked cycles before a bubble is requested from the pipeline
MAX_RETRY, 3, torn-read retries before an RV32 wide read reports an error
HI_OFFSET, 12'h010, address offset from a low CSR to its high half

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
PipeCSRReqM  in  1  pipeline CSR instruction valid in M
PipeCSRWriteM  in  1  pipeline write strobe
PipeCSRAdrM  in  12  pipeline CSR address
PipeCSRWriteValM  in  XLEN  pipeline write data
CSRAdrM  out  12  muxed address to CSR blocks
CSRWriteM  out  1  muxed write strobe
CSRWriteValM  out  XLEN  muxed write data
CSRReadValM  in  XLEN  read data from CSR blocks (combinational, same cycle)
IllegalCSRAccessM  in  1  illegal-access flag for the current address
DbgReqValid  in  1  debug request valid
DbgReqReady  out  1  request accepted when Valid&Ready
DbgWrite  in  1  1 = write, 0 = read
DbgWide  in  1  64-bit access (meaningful on RV32 only)
DbgAdr  in  12  CSR address (low half if wide)
DbgWData  in  64  write data
DbgRspValid  out  1  response valid; held until DbgRspReady
DbgRspReady  in  1  response consumed
DbgRspData  out  64  read data, zero-extended
DbgRspErr  out  1  illegal access or retry exhaustion
DbgStallReq  out  1  asks the hazard unit for one M-stage bubble

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; DbgReqReady=1; DbgRspValid=0; DbgRspErr=0; DbgRspData=0; DbgStallReq=0; starve counter=0; retry counter=0. A reset during any transaction abandons it: remaining beats are not issued and no response is sent.
- Mux: when PipeCSRReqM=1, CSR outputs pass the pipeline signals combinationally and no debug beat issues. Otherwise the pending debug beat, if any, drives the port. With neither active, CSRWriteM=0 and CSRAdrM=0.
- States: IDLE, B0, B1, B2, RESP.
  - IDLE: DbgReqReady=1. A handshake captures the request and enters B0. Ready=0 in every other state.
  - A beat completes only in a cycle where PipeCSRReqM=0. The state advances on the clk edge ending that cycle.
- Beat plans, by access type:
  - Narrow access, or XLEN=64: B0 only, at DbgAdr. A read captures CSRReadValM.
  - RV32 wide write: B0 writes 32'hFFFFFFFF to low. B1 writes DbgWData[63:32] to low+HI_OFFSET. B2 writes DbgWData[31:0] to low.
  - RV32 wide read: B0 reads high into H1. B1 reads low. B2 reads high into H2.
    - If H1==H2, the response is {H1, low}.
    - If H1!=H2, increment retry and return to B0. When retry reaches MAX_RETRY, go to RESP with Err=1.
- IllegalCSRAccessM=1 on any beat: the write strobe still reaches the CSR block, which suppresses it itself. Skip the remaining beats and go to RESP with Err=1 and Data=0.
- RESP: DbgRspValid=1 with Data/Err stable. On DbgRspReady, go to IDLE and clear retry. Valid and Ready may be coincident in the first RESP cycle.
- Latency: with an uncontended port, a narrow request accepted at cycle 0 issues its beat at cycle 1, and RspValid rises at cycle 2. An uncontended RV32 wide access raises RspValid at cycle 4.
- Starvation:
  - The counter increments in each B* cycle where PipeCSRReqM=1, and clears on beat completion or in IDLE.
  - At STARVE_LIMIT, DbgStallReq=1 until the next beat completes.
  - The counter saturates and does not wrap.
- High address is computed as a 12-bit sum; wrap-around past 12'hFFF is ignored.

Decomposition:
- Shared package: state enum (IDLE, B0, B1, B2, RESP), a beat-plan record (address-select hi/lo, write-value select), and the HI_OFFSET constant.
- One sub-module is natural: csr_dbg_beatgen, combinational. Maps {state, DbgWrite, DbgWide, XLEN} to the beat address, write value and next state.
- Starve and retry counters stay in the top module.

Test Plan:
- Narrow read, XLEN=64, no pipeline traffic, DbgAdr=12'h140 with CSRReadValM=64'h1234 -> one beat at 12'h140 with CSRWriteM=0; RspValid at cycle 2, Data=64'h1234, Err=0.
- RV32 wide write 64'h0000_0001_0000_0005 to 12'h14D -> write beats in order: 12'h14D←FFFFFFFF, 12'h15D←00000001, 12'h14D←00000005; then response Err=0.
- RV32 wide read where the high CSR returns 1 then 2, then stable 2 thereafter -> one retry.
  - Final response = {32'h2, low value}.
  - With a high value that changes every beat, Err=1 after 3 retries.
- PipeCSRReqM held high for 10 cycles during a pending narrow debug write -> no debug beat issues; pipeline signals pass through; DbgStallReq=1 from the 8th blocked cycle until the beat completes.
- IllegalCSRAccessM=1 on B0 of an RV32 wide write -> B1/B2 are not issued; response Err=1, Data=0.
- reset=0 asserted during B1 of a wide write -> B2 is never issued; DbgRspValid=0, DbgReqReady=1 after release.

Source files
------------

// File: rtl/csr_dbg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// csr_dbg_arbiter_pkg
// Shared types for the CSR debug arbiter: FSM state encoding, the per-beat
// plan record and the default low->high CSR address offset. plan_beat() is the
// single source of truth for the beat sequence of every access type.
// -----------------------------------------------------------------------------
package csr_dbg_arbiter_pkg;

  // Offset from a low CSR (e.g. STIMECMP) to its high half (STIMECMPH).
  localparam logic [11:0] HI_OFFSET_DEFAULT = 12'h010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_RESP
  } state_e;

  typedef enum logic {
    ADR_LO,
    ADR_HI
  } adr_sel_e;

  typedef enum logic [1:0] {
    WV_LO,    // DbgWData[XLEN-1:0] (the low word on RV32)
    WV_HI,    // DbgWData[63:32]
    WV_ONES   // all ones: parks the low half at its maximum
  } wval_sel_e;

  typedef struct packed {
    adr_sel_e  adr_sel;
    wval_sel_e wval_sel;
    logic      write;
    state_e    next_state;
  } beat_plan_t;

  // Beat plan for the beat issued in state st. `wide` must already be
  // qualified with RV32; on RV64 every access is a single beat.
  function automatic beat_plan_t plan_beat(state_e st, logic write, logic wide);
    beat_plan_t p;
    p = '{adr_sel: ADR_LO, wval_sel: WV_LO, write: 1'b0, next_state: ST_RESP};
    if (!wide) begin
      p.write = write;
    end else if (write) begin
      // Low half is parked at all-ones first so the 64-bit compare value
      // never passes through a smaller intermediate value while the high
      // half is being replaced: no spurious timer interrupt.
      case (st)
        ST_B0: begin
          p.wval_sel   = WV_ONES;
          p.write      = 1'b1;
          p.next_state = ST_B1;
        end
        ST_B1: begin
          p.adr_sel    = ADR_HI;
          p.wval_sel   = WV_HI;
          p.write      = 1'b1;
          p.next_state = ST_B2;
        end
        ST_B2: begin
          p.write      = 1'b1;
          p.next_state = ST_RESP;
        end
        default: ;
      endcase
    end else begin
      // high, low, high: the two high samples bracket the low read so a
      // carry between the halves is detected as a torn read.
      case (st)
        ST_B0: begin
          p.adr_sel    = ADR_HI;
          p.next_state = ST_B1;
        end
        ST_B1:   p.next_state = ST_B2;
        ST_B2:   p.adr_sel    = ADR_HI;
        default: ;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/csr_dbg_arbiter_if.sv
// -----------------------------------------------------------------------------
// csr_dbg_arbiter_if
// Bundles the pipeline CSR request, the muxed M-stage CSR port and the debug
// abstract-command request/response channel.
//   slave  : the arbiter's view (pipeline/debug/CSR-read side in, muxed port
//            and debug response out)
//   master : the surrounding system's view (the reverse)
// -----------------------------------------------------------------------------
interface csr_dbg_arbiter_if #(
  parameter int XLEN = 64
);

  // Pipeline side
  logic             PipeCSRReqM;
  logic             PipeCSRWriteM;
  logic [11:0]      PipeCSRAdrM;
  logic [XLEN-1:0]  PipeCSRWriteValM;
  // Muxed CSR port
  logic [11:0]      CSRAdrM;
  logic             CSRWriteM;
  logic [XLEN-1:0]  CSRWriteValM;
  logic [XLEN-1:0]  CSRReadValM;
  logic             IllegalCSRAccessM;
  // Debug request
  logic             DbgReqValid;
  logic             DbgReqReady;
  logic             DbgWrite;
  logic             DbgWide;
  logic [11:0]      DbgAdr;
  logic [63:0]      DbgWData;
  // Debug response
  logic             DbgRspValid;
  logic             DbgRspReady;
  logic [63:0]      DbgRspData;
  logic             DbgRspErr;
  logic             DbgStallReq;

  modport slave (
    input  PipeCSRReqM, PipeCSRWriteM, PipeCSRAdrM, PipeCSRWriteValM,
    input  CSRReadValM, IllegalCSRAccessM,
    input  DbgReqValid, DbgWrite, DbgWide, DbgAdr, DbgWData, DbgRspReady,
    output CSRAdrM, CSRWriteM, CSRWriteValM,
    output DbgReqReady, DbgRspValid, DbgRspData, DbgRspErr, DbgStallReq
  );

  modport master (
    output PipeCSRReqM, PipeCSRWriteM, PipeCSRAdrM, PipeCSRWriteValM,
    output CSRReadValM, IllegalCSRAccessM,
    output DbgReqValid, DbgWrite, DbgWide, DbgAdr, DbgWData, DbgRspReady,
    input  CSRAdrM, CSRWriteM, CSRWriteValM,
    input  DbgReqReady, DbgRspValid, DbgRspData, DbgRspErr, DbgStallReq
  );

endinterface

// File: rtl/csr_dbg_arbiter_beatgen.sv
// -----------------------------------------------------------------------------
// csr_dbg_arbiter_beatgen
// Purely combinational. Turns the current FSM state plus the captured debug
// request into the CSR address, write strobe and write value of the beat to
// issue, and the state to enter once that beat completes (before any
// illegal-access or torn-read override applied by the top).
// Ports:
//   state_i      current arbiter state
//   write_i      captured DbgWrite
//   wide_i       captured DbgWide, already qualified with RV32
//   adr_i        captured DbgAdr (low half for wide accesses)
//   wdata_i      captured DbgWData
//   beat_adr_o   CSR address of this beat
//   beat_write_o write strobe of this beat
//   beat_wval_o  write value of this beat
//   next_state_o state after this beat completes normally
// -----------------------------------------------------------------------------
module csr_dbg_arbiter_beatgen
  import csr_dbg_arbiter_pkg::*;
#(
  parameter int          XLEN      = 64,
  parameter logic [11:0] HI_OFFSET = HI_OFFSET_DEFAULT
) (
  input  state_e            state_i,
  input  logic              write_i,
  input  logic              wide_i,
  input  logic [11:0]       adr_i,
  input  logic [63:0]       wdata_i,
  output logic [11:0]       beat_adr_o,
  output logic              beat_write_o,
  output logic [XLEN-1:0]   beat_wval_o,
  output state_e            next_state_o
);

  beat_plan_t plan;

  // NOTE: every output of a combinational block is assigned on every path
  // (here via the function result and a defaulted case); a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    plan         = plan_beat(state_i, write_i, wide_i);
    // 12-bit sum: an offset past 12'hFFF simply wraps.
    beat_adr_o   = (plan.adr_sel == ADR_HI) ? adr_i + HI_OFFSET : adr_i;
    beat_write_o = plan.write;
    next_state_o = plan.next_state;
    case (plan.wval_sel)
      WV_ONES: beat_wval_o = '1;
      WV_HI:   beat_wval_o = XLEN'(wdata_i[63:32]);
      default: beat_wval_o = wdata_i[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/csr_dbg_arbiter.sv
// -----------------------------------------------------------------------------
// csr_dbg_arbiter
// Shares the M-stage CSR port between the pipeline and the debug module's
// abstract-command interface. The pipeline always wins; debug beats issue in
// slots where PipeCSRReqM is low. On RV32 a wide (64-bit) debug access to a
// low/high CSR pair is sequenced as three beats so that writes never expose a
// smaller intermediate compare value and reads detect carries between halves
// (retrying up to MAX_RETRY times).
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    csr_dbg_arbiter_if.slave: pipeline request, muxed CSR port,
//          debug request/response and the bubble request to the hazard unit
// -----------------------------------------------------------------------------
module csr_dbg_arbiter
  import csr_dbg_arbiter_pkg::*;
#(
  parameter int          XLEN         = 64,
  parameter int          STARVE_LIMIT = 8,
  parameter int          MAX_RETRY    = 3,
  parameter logic [11:0] HI_OFFSET    = HI_OFFSET_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  csr_dbg_arbiter_if.slave    bus
);

  localparam logic IS_RV32  = (XLEN == 32);
  localparam int   STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int   RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_PRE = STARVE_W'(STARVE_LIMIT - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                req_write_q, req_write_d;
  logic                req_wide_q, req_wide_d;
  logic [11:0]         req_adr_q, req_adr_d;
  logic [63:0]         req_wdata_q, req_wdata_d;
  logic [31:0]         hi_first_q, hi_first_d;   // H1 of a wide read
  logic [31:0]         lo_word_q, lo_word_d;     // low half of a wide read
  logic [63:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;

  // ---------------------------------------------------------------------------
  // Derived controls
  // ---------------------------------------------------------------------------
  logic            in_beat;        // a debug beat is pending
  logic            beat_done;      // ...and the port is free this cycle
  logic            req_fire;
  logic            rsp_fire;
  logic            hi_torn;        // H2 differs from H1
  logic            retry_restart;  // wide read B2 completed with a torn high
  logic            retry_exhausted;

  logic [11:0]     beat_adr;
  logic            beat_write;
  logic [XLEN-1:0] beat_wval;
  state_e          plan_next;

  assign in_beat         = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
  assign beat_done       = in_beat && !bus.PipeCSRReqM;
  assign req_fire        = (state_q == ST_IDLE) && bus.DbgReqValid;
  assign rsp_fire        = (state_q == ST_RESP) && bus.DbgRspReady;
  assign hi_torn         = (bus.CSRReadValM[31:0] != hi_first_q);
  assign retry_restart   = req_wide_q && !req_write_q && (state_q == ST_B2) && hi_torn;
  assign retry_exhausted = (retry_q >= RETRY_LAST);

  csr_dbg_arbiter_beatgen #(
    .XLEN      (XLEN),
    .HI_OFFSET (HI_OFFSET)
  ) u_beatgen (
    .state_i      (state_q),
    .write_i      (req_write_q),
    .wide_i       (req_wide_q),
    .adr_i        (req_adr_q),
    .wdata_i      (req_wdata_q),
    .beat_adr_o   (beat_adr),
    .beat_write_o (beat_write),
    .beat_wval_o  (beat_wval),
    .next_state_o (plan_next)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.DbgReqValid) state_d = ST_B0;
      ST_B0, ST_B1, ST_B2: begin
        if (beat_done) begin
          if (bus.IllegalCSRAccessM) state_d = ST_RESP;
          else if (retry_restart)    state_d = retry_exhausted ? ST_RESP : ST_B0;
          else                       state_d = plan_next;
        end
      end
      ST_RESP: if (bus.DbgRspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request capture, read assembly, counters
  // ---------------------------------------------------------------------------
  always_comb begin
    req_write_d = req_write_q;
    req_wide_d  = req_wide_q;
    req_adr_d   = req_adr_q;
    req_wdata_d = req_wdata_q;
    hi_first_d  = hi_first_q;
    lo_word_d   = lo_word_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    starve_d    = starve_q;
    retry_d     = retry_q;

    if (req_fire) begin
      req_write_d = bus.DbgWrite;
      req_wide_d  = bus.DbgWide & IS_RV32;
      req_adr_d   = bus.DbgAdr;
      req_wdata_d = bus.DbgWData;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;
    end

    if (in_beat) begin
      // Counts blocked beat cycles; saturates rather than wrapping.
      if (beat_done)                  starve_d = '0;
      else if (starve_q != STARVE_MAX) starve_d = starve_q + STARVE_W'(1);

      if (beat_done) begin
        if (bus.IllegalCSRAccessM) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else if (!req_wide_q) begin
          if (!req_write_q) rsp_data_d = 64'(bus.CSRReadValM);
        end else if (!req_write_q) begin
          case (state_q)
            ST_B0: hi_first_d = bus.CSRReadValM[31:0];
            ST_B1: lo_word_d  = bus.CSRReadValM[31:0];
            default: begin
              if (!hi_torn) begin
                rsp_data_d = {hi_first_q, lo_word_q};
              end else begin
                retry_d = retry_q + RETRY_W'(1);
                if (retry_exhausted) rsp_err_d = 1'b1;
              end
            end
          endcase
        end
      end
    end else begin
      starve_d = '0;
    end

    if (rsp_fire) retry_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_write_q <= 1'b0;
      req_wide_q  <= 1'b0;
      req_adr_q   <= '0;
      req_wdata_q <= '0;
      hi_first_q  <= '0;
      lo_word_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      starve_q    <= '0;
      retry_q     <= '0;
    end else begin
      req_write_q <= req_write_d;
      req_wide_q  <= req_wide_d;
      req_adr_q   <= req_adr_d;
      req_wdata_q <= req_wdata_d;
      hi_first_q  <= hi_first_d;
      lo_word_q   <= lo_word_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      starve_q    <= starve_d;
      retry_q     <= retry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and CSR port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.DbgReqReady = (state_q == ST_IDLE);
    bus.DbgRspValid = (state_q == ST_RESP);
    bus.DbgRspData  = rsp_data_q;
    bus.DbgRspErr   = rsp_err_q;
    // Raised in the blocked cycle that brings the count to the limit, and
    // held until the beat finally completes.
    bus.DbgStallReq = in_beat &&
                      ((starve_q == STARVE_MAX) ||
                       (bus.PipeCSRReqM && (starve_q == STARVE_PRE)));

    if (bus.PipeCSRReqM) begin
      bus.CSRAdrM      = bus.PipeCSRAdrM;
      bus.CSRWriteM    = bus.PipeCSRWriteM;
      bus.CSRWriteValM = bus.PipeCSRWriteValM;
    end else if (in_beat) begin
      bus.CSRAdrM      = beat_adr;
      bus.CSRWriteM    = beat_write;
      bus.CSRWriteValM = beat_wval;
    end else begin
      bus.CSRAdrM      = '0;
      bus.CSRWriteM    = 1'b0;
      bus.CSRWriteValM = '0;
    end
  end

endmodule

// File: tb/tb_csr_dbg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_csr_dbg_arbiter
// Directed bench for csr_dbg_arbiter. One RV64 and one RV32 instance share
// clk/reset. Inputs change #1 after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_csr_dbg_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  csr_dbg_arbiter_if #(.XLEN(64)) if64 ();
  csr_dbg_arbiter_if #(.XLEN(32)) if32 ();

  csr_dbg_arbiter #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));
  csr_dbg_arbiter #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if64.PipeCSRReqM = 0; if64.PipeCSRWriteM = 0; if64.PipeCSRAdrM = '0; if64.PipeCSRWriteValM = '0;
    if64.CSRReadValM = '0; if64.IllegalCSRAccessM = 0; if64.DbgReqValid = 0; if64.DbgWrite = 0;
    if64.DbgWide = 0; if64.DbgAdr = '0; if64.DbgWData = '0; if64.DbgRspReady = 0;
    if32.PipeCSRReqM = 0; if32.PipeCSRWriteM = 0; if32.PipeCSRAdrM = '0; if32.PipeCSRWriteValM = '0;
    if32.CSRReadValM = '0; if32.IllegalCSRAccessM = 0; if32.DbgReqValid = 0; if32.DbgWrite = 0;
    if32.DbgWide = 0; if32.DbgAdr = '0; if32.DbgWData = '0; if32.DbgRspReady = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    @(negedge clk);
    n_checks++; if (if64.DbgReqReady !== 1'b1) begin n_errors++; $display("FAIL rst64_ready: got %b want 1", if64.DbgReqReady); end
    n_checks++; if (if64.DbgRspValid !== 1'b0) begin n_errors++; $display("FAIL rst64_rspvalid: got %b want 0", if64.DbgRspValid); end
    n_checks++; if (if64.DbgRspData !== 64'h0) begin n_errors++; $display("FAIL rst64_rspdata: got %h want 0", if64.DbgRspData); end
    n_checks++; if (if64.DbgRspErr !== 1'b0) begin n_errors++; $display("FAIL rst64_rsperr: got %b want 0", if64.DbgRspErr); end
    n_checks++; if (if64.DbgStallReq !== 1'b0) begin n_errors++; $display("FAIL rst64_stall: got %b want 0", if64.DbgStallReq); end
    n_checks++; if (if64.CSRWriteM !== 1'b0 || if64.CSRAdrM !== 12'h0) begin n_errors++; $display("FAIL rst64_port: got we=%b adr=%h want we=0 adr=000", if64.CSRWriteM, if64.CSRAdrM); end
    n_checks++; if (if32.DbgReqReady !== 1'b1 || if32.DbgRspValid !== 1'b0) begin n_errors++; $display("FAIL rst32_hs: got ready=%b valid=%b want 1/0", if32.DbgReqReady, if32.DbgRspValid); end
    reset = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (if32.DbgReqReady !== 1'b1 || if32.DbgStallReq !== 1'b0) begin n_errors++; $display("FAIL rst32_after: got ready=%b stall=%b want 1/0", if32.DbgReqReady, if32.DbgStallReq); end
    step();
  endtask

  // ---------------------------------------------------------------------------
  // RV64: narrow read, and a "wide" read that must still be a single beat.
  task automatic test_narrow_read();
    logic [11:0] adr [2]  = '{12'h140, 12'h14D};
    logic        wide [2] = '{1'b0, 1'b1};
    logic [63:0] rdv [2]  = '{64'h1234, 64'hFEDC_BA98_7654_3210};
    for (int v = 0; v < 2; v++) begin
      if64.DbgReqValid = 1; if64.DbgWrite = 0; if64.DbgWide = wide[v]; if64.DbgAdr = adr[v];
      if64.CSRReadValM = rdv[v];
      @(negedge clk);
      n_checks++; if (if64.DbgReqReady !== 1'b1) begin n_errors++; $display("FAIL nr%0d_ready_c0: got %b want 1", v, if64.DbgReqReady); end
      step();
      if64.DbgReqValid = 0;
      @(negedge clk);
      n_checks++; if (if64.CSRAdrM !== adr[v] || if64.CSRWriteM !== 1'b0) begin n_errors++; $display("FAIL nr%0d_beat_c1: got adr=%h we=%b want adr=%h we=0", v, if64.CSRAdrM, if64.CSRWriteM, adr[v]); end
      n_checks++; if (if64.DbgRspValid !== 1'b0) begin n_errors++; $display("FAIL nr%0d_rspvalid_c1: got %b want 0", v, if64.DbgRspValid); end
      step();
      @(negedge clk);
      n_checks++; if (if64.DbgRspValid !== 1'b1) begin n_errors++; $display("FAIL nr%0d_rspvalid_c2: got %b want 1", v, if64.DbgRspValid); end
      n_checks++; if (if64.DbgRspData !== rdv[v] || if64.DbgRspErr !== 1'b0) begin n_errors++; $display("FAIL nr%0d_rsp: got data=%h err=%b want data=%h err=0", v, if64.DbgRspData, if64.DbgRspErr, rdv[v]); end
      n_checks++; if (if64.CSRWriteM !== 1'b0 || if64.CSRAdrM !== 12'h0) begin n_errors++; $display("FAIL nr%0d_noextra: got we=%b adr=%h want 0/000", v, if64.CSRWriteM, if64.CSRAdrM); end
      if64.DbgRspReady = 1;
      step();
      if64.DbgRspReady = 0;
      @(negedge clk);
      n_checks++; if (if64.DbgReqReady !== 1'b1 || if64.DbgRspValid !== 1'b0) begin n_errors++; $display("FAIL nr%0d_idle: got ready=%b valid=%b want 1/0", v, if64.DbgReqReady, if64.DbgRspValid); end
      step();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wide_write();
    logic [11:0] exp_adr [3] = '{12'h14D, 12'h15D, 12'h14D};
    logic [31:0] exp_wv  [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0005};
    if32.DbgReqValid = 1; if32.DbgWrite = 1; if32.DbgWide = 1; if32.DbgAdr = 12'h14D;
    if32.DbgWData = 64'h0000_0001_0000_0005;
    step();
    if32.DbgReqValid = 0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      n_checks++; if (if32.CSRAdrM !== exp_adr[b] || if32.CSRWriteM !== 1'b1 || if32.CSRWriteValM !== exp_wv[b]) begin
        n_errors++; $display("FAIL ww_beat%0d: got adr=%h we=%b val=%h want adr=%h we=1 val=%h", b, if32.CSRAdrM, if32.CSRWriteM, if32.CSRWriteValM, exp_adr[b], exp_wv[b]);
      end
      n_checks++; if (if32.DbgRspValid !== 1'b0 || if32.DbgReqReady !== 1'b0) begin n_errors++; $display("FAIL ww_hs%0d: got valid=%b ready=%b want 0/0", b, if32.DbgRspValid, if32.DbgReqReady); end
      step();
    end
    @(negedge clk);
    n_checks++; if (if32.DbgRspValid !== 1'b1 || if32.DbgRspErr !== 1'b0) begin n_errors++; $display("FAIL ww_rsp_c4: got valid=%b err=%b want 1/0", if32.DbgRspValid, if32.DbgRspErr); end
    n_checks++; if (if32.CSRWriteM !== 1'b0) begin n_errors++; $display("FAIL ww_noextra: got we=%b want 0", if32.CSRWriteM); end
    if32.DbgRspReady = 1;
    step();
    if32.DbgRspReady = 0;
  endtask

  // ---------------------------------------------------------------------------
  // High half changes on every sample: three torn passes, then error.
  task automatic test_wide_read_exhaust();
    logic [11:0] exp_adr [3] = '{12'h15D, 12'h14D, 12'h15D};
    logic [31:0] rd [9] = '{32'h1, 32'h0000_AAAA, 32'h2,
                            32'h3, 32'h0000_AAAA, 32'h4,
                            32'h5, 32'h0000_AAAA, 32'h6};
    if32.DbgReqValid = 1; if32.DbgWrite = 0; if32.DbgWide = 1; if32.DbgAdr = 12'h14D;
    step();
    if32.DbgReqValid = 0;
    for (int b = 0; b < 9; b++) begin
      if32.CSRReadValM = rd[b];
      @(negedge clk);
      n_checks++; if (if32.CSRAdrM !== exp_adr[b % 3] || if32.CSRWriteM !== 1'b0 || if32.DbgRspValid !== 1'b0) begin
        n_errors++; $display("FAIL rx_beat%0d: got adr=%h we=%b valid=%b want adr=%h we=0 valid=0", b, if32.CSRAdrM, if32.CSRWriteM, if32.DbgRspValid, exp_adr[b % 3]);
      end
      step();
    end
    @(negedge clk);
    n_checks++; if (if32.DbgRspValid !== 1'b1 || if32.DbgRspErr !== 1'b1 || if32.DbgRspData !== 64'h0) begin
      n_errors++; $display("FAIL rx_rsp: got valid=%b err=%b data=%h want 1/1/0", if32.DbgRspValid, if32.DbgRspErr, if32.DbgRspData);
    end
    if32.DbgRspReady = 1;
    step();
    if32.DbgRspReady = 0;
  endtask

  // ---------------------------------------------------------------------------
  // High half returns 1 then a stable 2: exactly one retry.
  task automatic test_wide_read_retry();
    logic [11:0] exp_adr [3] = '{12'h15D, 12'h14D, 12'h15D};
    logic [31:0] rd [6] = '{32'h1, 32'h1111_0000, 32'h2,
                            32'h2, 32'h2222_0000, 32'h2};
    if32.DbgReqValid = 1; if32.DbgWrite = 0; if32.DbgWide = 1; if32.DbgAdr = 12'h14D;
    step();
    if32.DbgReqValid = 0;
    for (int b = 0; b < 6; b++) begin
      if32.CSRReadValM = rd[b];
      @(negedge clk);
      n_checks++; if (if32.CSRAdrM !== exp_adr[b % 3] || if32.CSRWriteM !== 1'b0 || if32.DbgRspValid !== 1'b0) begin
        n_errors++; $display("FAIL rr_beat%0d: got adr=%h we=%b valid=%b want adr=%h we=0 valid=0", b, if32.CSRAdrM, if32.CSRWriteM, if32.DbgRspValid, exp_adr[b % 3]);
      end
      step();
    end
    @(negedge clk);
    n_checks++; if (if32.DbgRspValid !== 1'b1 || if32.DbgRspErr !== 1'b0 || if32.DbgRspData !== 64'h0000_0002_2222_0000) begin
      n_errors++; $display("FAIL rr_rsp: got valid=%b err=%b data=%h want 1/0/0000000222220000", if32.DbgRspValid, if32.DbgRspErr, if32.DbgRspData);
    end
    if32.DbgRspReady = 1;
    step();
    if32.DbgRspReady = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Pipeline holds the port for 10 cycles over a pending narrow write.
  task automatic test_starve();
    logic exp_stall;
    if64.DbgReqValid = 1; if64.DbgWrite = 1; if64.DbgWide = 0; if64.DbgAdr = 12'h300;
    if64.DbgWData = 64'hDEAD_BEEF_0000_0001;
    step();
    if64.DbgReqValid = 0;
    if64.PipeCSRReqM = 1; if64.PipeCSRWriteM = 1; if64.PipeCSRAdrM = 12'h7C0; if64.PipeCSRWriteValM = 64'h55;
    for (int i = 1; i <= 10; i++) begin
      exp_stall = (i >= 8);
      @(negedge clk);
      n_checks++; if (if64.CSRAdrM !== 12'h7C0 || if64.CSRWriteM !== 1'b1 || if64.CSRWriteValM !== 64'h55) begin
        n_errors++; $display("FAIL st_pass%0d: got adr=%h we=%b val=%h want 7c0/1/55", i, if64.CSRAdrM, if64.CSRWriteM, if64.CSRWriteValM);
      end
      n_checks++; if (if64.DbgStallReq !== exp_stall) begin n_errors++; $display("FAIL st_stall%0d: got %b want %b", i, if64.DbgStallReq, exp_stall); end
      step();
    end
    if64.PipeCSRReqM = 0; if64.PipeCSRWriteM = 0; if64.PipeCSRAdrM = '0; if64.PipeCSRWriteValM = '0;
    @(negedge clk);
    n_checks++; if (if64.CSRAdrM !== 12'h300 || if64.CSRWriteM !== 1'b1 || if64.CSRWriteValM !== 64'hDEAD_BEEF_0000_0001) begin
      n_errors++; $display("FAIL st_beat: got adr=%h we=%b val=%h want 300/1/deadbeef00000001", if64.CSRAdrM, if64.CSRWriteM, if64.CSRWriteValM);
    end
    n_checks++; if (if64.DbgStallReq !== 1'b1) begin n_errors++; $display("FAIL st_stall_done: got %b want 1", if64.DbgStallReq); end
    step();
    @(negedge clk);
    n_checks++; if (if64.DbgRspValid !== 1'b1 || if64.DbgRspErr !== 1'b0 || if64.DbgStallReq !== 1'b0) begin
      n_errors++; $display("FAIL st_rsp: got valid=%b err=%b stall=%b want 1/0/0", if64.DbgRspValid, if64.DbgRspErr, if64.DbgStallReq);
    end
    if64.DbgRspReady = 1;
    step();
    if64.DbgRspReady = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Illegal on B0 of a wide write; response accepted in its first cycle.
  task automatic test_illegal();
    if32.DbgReqValid = 1; if32.DbgWrite = 1; if32.DbgWide = 1; if32.DbgAdr = 12'h14D;
    if32.DbgWData = 64'h0000_0001_0000_0005;
    step();
    if32.DbgReqValid = 0;
    if32.IllegalCSRAccessM = 1;
    @(negedge clk);
    n_checks++; if (if32.CSRAdrM !== 12'h14D || if32.CSRWriteM !== 1'b1 || if32.CSRWriteValM !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL il_b0: got adr=%h we=%b val=%h want 14d/1/ffffffff", if32.CSRAdrM, if32.CSRWriteM, if32.CSRWriteValM);
    end
    step();
    if32.IllegalCSRAccessM = 0;
    @(negedge clk);
    n_checks++; if (if32.DbgRspValid !== 1'b1 || if32.DbgRspErr !== 1'b1 || if32.DbgRspData !== 64'h0) begin
      n_errors++; $display("FAIL il_rsp: got valid=%b err=%b data=%h want 1/1/0", if32.DbgRspValid, if32.DbgRspErr, if32.DbgRspData);
    end
    n_checks++; if (if32.CSRWriteM !== 1'b0) begin n_errors++; $display("FAIL il_no_b1: got we=%b want 0", if32.CSRWriteM); end
    if32.DbgRspReady = 1;
    step();
    if32.DbgRspReady = 0;
    @(negedge clk);
    n_checks++; if (if32.DbgReqReady !== 1'b1 || if32.DbgRspValid !== 1'b0 || if32.CSRWriteM !== 1'b0) begin
      n_errors++; $display("FAIL il_idle: got ready=%b valid=%b we=%b want 1/0/0", if32.DbgReqReady, if32.DbgRspValid, if32.CSRWriteM);
    end
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Reset asserted during B1 of a wide write abandons the transaction.
  task automatic test_reset_mid();
    if32.DbgReqValid = 1; if32.DbgWrite = 1; if32.DbgWide = 1; if32.DbgAdr = 12'h14D;
    if32.DbgWData = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    if32.DbgReqValid = 0;
    @(negedge clk);
    n_checks++; if (if32.CSRAdrM !== 12'h14D || if32.CSRWriteM !== 1'b1) begin n_errors++; $display("FAIL rm_b0: got adr=%h we=%b want 14d/1", if32.CSRAdrM, if32.CSRWriteM); end
    step();
    @(negedge clk);
    n_checks++; if (if32.CSRAdrM !== 12'h15D || if32.CSRWriteValM !== 32'hAAAA_BBBB) begin n_errors++; $display("FAIL rm_b1: got adr=%h val=%h want 15d/aaaabbbb", if32.CSRAdrM, if32.CSRWriteValM); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (if32.CSRWriteM !== 1'b0 || if32.DbgRspValid !== 1'b0 || if32.DbgReqReady !== 1'b1) begin
        n_errors++; $display("FAIL rm_after%0d: got we=%b valid=%b ready=%b want 0/0/1", i, if32.CSRWriteM, if32.DbgRspValid, if32.DbgReqReady);
      end
      step();
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_narrow_read();
    test_wide_write();
    test_wide_read_exhaust();
    test_wide_read_retry();
    test_starve();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
